// File: rtl/main_pkg.sv
// Shared types and constants for the RMII motor-control top level.
// The beacon ROM builder is only referenced when MAIN_TX_BEACON_EN is defined.
package main_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GAP
    } tx_state_e;

    localparam logic [1:0] DIBIT_PRE = 2'b01;
    localparam logic [1:0] DIBIT_SFD = 2'b11;

    localparam logic [7:0] BYTE_PRE = 8'h55;
    localparam logic [7:0] BYTE_SFD = 8'hD5;

    localparam int BEACON_BYTES  = 72;
    localparam int BEACON_GAP    = 48;
    localparam int BEACON_DIBITS = BEACON_BYTES * 4;

    // Elaboration-time ROM image: preamble, SFD, 60-byte broadcast payload and
    // its reflected CRC-32 FCS, sent least-significant byte first.
    function automatic logic [BEACON_BYTES*8-1:0] beacon_rom();
        logic [BEACON_BYTES*8-1:0] rom;
        logic [31:0]               crc;
        logic [7:0]                b;
        rom = '0;
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < BEACON_BYTES - 4; i++) begin
            if (i < 7)        b = BYTE_PRE;
            else if (i == 7)  b = BYTE_SFD;
            else if (i < 14)  b = 8'hFF;
            else if (i == 14) b = 8'h02;
            else if (i < 19)  b = 8'h00;
            else if (i == 19) b = 8'h01;
            else if (i == 20) b = 8'h88;
            else if (i == 21) b = 8'hB5;
            else              b = 8'(i - 22);
            rom[i*8 +: 8] = b;
            if (i >= 8) begin
                crc = crc ^ {24'h0, b};
                for (int k = 0; k < 8; k++)
                    crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
            end
        end
        crc = ~crc;
        for (int j = 0; j < 4; j++)
            rom[(BEACON_BYTES - 4 + j)*8 +: 8] = crc[j*8 +: 8];
        return rom;
    endfunction

endpackage

// File: rtl/rmii_rx_frame.sv
// RMII receive framing: preamble/SFD hunt, LSB-first byte assembly, command
// capture and a one-cycle good/bad verdict when carrier drops.
module rmii_rx_frame
    import main_pkg::*;
#(
    parameter int MIN_BYTES  = 64,
    parameter int CMD_OFFSET = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       crs_dv,
    input  logic [1:0] rxd,
    input  logic       rx_er,
    output logic       good_pulse,
    output logic       bad_pulse,
    output logic [7:0] cmd
);

    localparam logic [10:0] MIN_CNT      = 11'(MIN_BYTES);
    localparam logic [10:0] CMD_IDX      = 11'(CMD_OFFSET);
    localparam logic [10:0] BYTE_CNT_MAX = 11'd2047;

    rx_state_e   state, state_nxt;
    logic [1:0]  dibit_idx;
    logic [10:0] byte_cnt;
    logic [7:0]  byte_sr;
    logic [7:0]  shadow;
    logic [7:0]  byte_full;
    logic        frame_end;

    assign byte_full  = {rxd, byte_sr[7:2]};
    assign frame_end  = (state == DATA) && !crs_dv;
    assign good_pulse = frame_end && (dibit_idx == 2'd0) && (byte_cnt >= MIN_CNT) && !rx_er;
    assign bad_pulse  = (frame_end && !good_pulse) || ((state == DROP) && !crs_dv);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next state defaults to the current one before the case, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (crs_dv && rxd == DIBIT_PRE) state_nxt = PRE;
            PRE: begin
                if (!crs_dv)               state_nxt = IDLE;
                else if (rxd == DIBIT_SFD) state_nxt = DATA;
                else if (rxd != DIBIT_PRE) state_nxt = IDLE;
            end
            DATA: begin
                if (!crs_dv)    state_nxt = IDLE;
                else if (rx_er) state_nxt = DROP;
            end
            DROP:    if (!crs_dv) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dibit_idx <= 2'd0;
            byte_cnt  <= 11'd0;
            byte_sr   <= 8'h00;
            shadow    <= 8'h00;
            cmd       <= 8'h00;
        end else begin
            if (state == PRE && crs_dv && rxd == DIBIT_SFD) begin
                dibit_idx <= 2'd0;
                byte_cnt  <= 11'd0;
            end else if (state == DATA && crs_dv) begin
                byte_sr   <= byte_full;
                dibit_idx <= dibit_idx + 2'd1;
                if (dibit_idx == 2'd3) begin
                    if (byte_cnt == CMD_IDX)      shadow   <= byte_full;
                    if (byte_cnt != BYTE_CNT_MAX) byte_cnt <= byte_cnt + 11'd1;
                end
            end
            if (good_pulse) cmd <= shadow;
        end
    end

endmodule

// File: rtl/main_rmii_top.sv
// Tang Nano 9K motor-control top: RMII frame receive, command latch, status LEDs,
// MDC generation. Define MAIN_TX_BEACON_EN to build the BTN2-triggered TX beacon.
module main_rmii_top
    import main_pkg::*;
#(
    parameter int HB_BITS    = 25,
    parameter int MDC_DIV    = 20,
    parameter int MIN_BYTES  = 64,
    parameter int CMD_OFFSET = 14
) (
    input  logic       CLK50,
    input  logic       BTN1,
    input  logic       CLK,
    input  logic       BTN2,
    input  logic       RMII_CRS_DV,
    input  logic [1:0] RMII_RXD,
    input  logic       RMII_RX_ER,
    output logic       RMII_TX_EN,
    output logic [1:0] RMII_TXD,
    output logic       RMII_MDC,
    inout  wire        RMII_MDIO,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3
);

    localparam int MDC_HALF = MDC_DIV / 2;
    localparam int MDC_W    = $clog2(MDC_HALF + 1);

    logic [1:0]         rst_sync;
    logic               rst_n;
    logic [1:0]         btn_sync;
    logic               btn_prev;
    logic               btn_press;
    logic [HB_BITS-1:0] hb_cnt;
    logic [MDC_W-1:0]   mdc_cnt;
    logic               rx_good;
    logic               rx_bad;
    logic [7:0]         cmd;
    wire                unused_ok = &{1'b0, CLK, cmd};

    assign RMII_MDIO = 1'bz;
    assign rst_n     = rst_sync[1];

    // Asserts with BTN1 immediately; releases only after two clean CLK50 edges.
    always_ff @(posedge CLK50 or negedge BTN1) begin
        if (!BTN1) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= 2'b11;
            btn_prev <= 1'b1;
            hb_cnt   <= '0;
            mdc_cnt  <= '0;
            RMII_MDC <= 1'b0;
        end else begin
            btn_sync <= {btn_sync[0], BTN2};
            btn_prev <= btn_sync[1];
            hb_cnt   <= hb_cnt + HB_BITS'(1);
            if (mdc_cnt == MDC_W'(MDC_HALF - 1)) begin
                mdc_cnt  <= '0;
                RMII_MDC <= ~RMII_MDC;
            end else begin
                mdc_cnt <= mdc_cnt + MDC_W'(1);
            end
        end
    end

    assign btn_press = btn_prev & ~btn_sync[1];
    assign LED1      = ~hb_cnt[HB_BITS-1];

    rmii_rx_frame #(
        .MIN_BYTES (MIN_BYTES),
        .CMD_OFFSET(CMD_OFFSET)
    ) u_rx_frame (
        .clk       (CLK50),
        .rst_n     (rst_n),
        .crs_dv    (RMII_CRS_DV),
        .rxd       (RMII_RXD),
        .rx_er     (RMII_RX_ER),
        .good_pulse(rx_good),
        .bad_pulse (rx_bad),
        .cmd       (cmd)
    );

    // A clear request wins over a simultaneous bad verdict.
    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) begin
            LED2 <= 1'b1;
            LED3 <= 1'b1;
        end else begin
            if (rx_good)                LED2 <= ~LED2;
            if (rx_good || btn_press)   LED3 <= 1'b1;
            else if (rx_bad)            LED3 <= 1'b0;
        end
    end

`ifdef MAIN_TX_BEACON_EN
    localparam logic [BEACON_BYTES*8-1:0] TX_ROM = beacon_rom();
    localparam logic [8:0] TX_SEND_LAST = 9'(BEACON_DIBITS - 1);
    localparam logic [8:0] TX_GAP_LAST  = 9'(BEACON_GAP - 1);

    tx_state_e  tx_state, tx_state_nxt;
    logic [8:0] tx_cnt;
    logic [7:0] tx_byte;

    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 9'd0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_state != tx_state_nxt) tx_cnt <= 9'd0;
            else if (tx_state != TX_IDLE) tx_cnt <= tx_cnt + 9'd1;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE: if (btn_press) tx_state_nxt = TX_SEND;
            TX_SEND: if (tx_cnt == TX_SEND_LAST) tx_state_nxt = TX_GAP;
            TX_GAP:  if (tx_cnt == TX_GAP_LAST)  tx_state_nxt = TX_IDLE;
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    assign tx_byte    = TX_ROM[{tx_cnt[8:2], 3'b000} +: 8];
    assign RMII_TX_EN = (tx_state == TX_SEND);
    assign RMII_TXD   = RMII_TX_EN ? tx_byte[{tx_cnt[1:0], 1'b0} +: 2] : 2'b00;
`else
    assign RMII_TX_EN = 1'b0;
    assign RMII_TXD   = 2'b00;
`endif

endmodule

// File: tb/tb_main_rmii_top.sv
// Directed bench for main_rmii_top with a frame-level reference model and a
// per-cycle compare on the falling edge of CLK50.
module tb_main_rmii_top;

    logic       CLK50 = 1'b0;
    logic       BTN1  = 1'b0;
    logic       CLK   = 1'b0;
    logic       BTN2  = 1'b1;
    logic       crs   = 1'b0;
    logic [1:0] rxd   = 2'b00;
    logic       er    = 1'b0;
    wire        TX_EN;
    wire  [1:0] TXD;
    wire        MDC;
    wire        MDIO;
    wire        LED1, LED2, LED3;

    int         errors = 0;
    int         checks = 0;
    int         n_edges = 0;
    logic       exp_led2 = 1'b1;
    logic       exp_led3 = 1'b1;
    logic [7:0] exp_cmd  = 8'h00;

    main_rmii_top #(
        .HB_BITS   (4),
        .MDC_DIV   (20),
        .MIN_BYTES (64),
        .CMD_OFFSET(14)
    ) dut (
        .CLK50      (CLK50),
        .BTN1       (BTN1),
        .CLK        (CLK),
        .BTN2       (BTN2),
        .RMII_CRS_DV(crs),
        .RMII_RXD   (rxd),
        .RMII_RX_ER (er),
        .RMII_TX_EN (TX_EN),
        .RMII_TXD   (TXD),
        .RMII_MDC   (MDC),
        .RMII_MDIO  (MDIO),
        .LED1       (LED1),
        .LED2       (LED2),
        .LED3       (LED3)
    );

    always #10 CLK50 = ~CLK50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Edges seen with BTN1 released; the first two only clear the reset synchroniser.
    always @(posedge CLK50) begin
        if (!BTN1) n_edges = 0;
        else       n_edges++;
    end

    always @(negedge CLK50) begin
        int k;
        k = (!BTN1 || n_edges <= 2) ? 0 : n_edges - 2;
        check("led1_heartbeat", LED1, ((k / 8) % 2) == 0);
        check("mdc_divider", MDC, (k / 10) % 2);
        check("led2_model", LED2, exp_led2);
        check("led3_model", LED3, exp_led3);
        check("cmd_model", dut.u_rx_frame.cmd, exp_cmd);
`ifndef MAIN_TX_BEACON_EN
        check("tx_en_idle", TX_EN, 0);
        check("txd_idle", TXD, 0);
`endif
        check("no_x_outputs", $isunknown({LED1, LED2, LED3, TX_EN, TXD, MDC}), 0);
    end

    task automatic drive(input logic c, input logic [1:0] d, input logic e);
        @(posedge CLK50);
        #1;
        crs = c;
        rxd = d;
        er  = e;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        for (int j = 0; j < 4; j++) drive(1'b1, b[2*j +: 2], e && (j == 0));
    endtask

    // Sends a frame and applies its expected effect one cycle after carrier drops.
    task automatic send_frame(input int nbytes, input logic [7:0] cmd_b, input int err_at, input int extra);
        logic good;
        for (int i = 0; i < 31; i++) drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < nbytes; i++) send_byte((i == 14) ? cmd_b : 8'(i * 7 + 3), i == err_at);
        for (int i = 0; i < extra; i++) drive(1'b1, 2'b10, 1'b0);
        drive(1'b0, 2'b00, 1'b0);
        @(posedge CLK50);
        #1;
        good = (nbytes >= 64) && (err_at < 0) && (extra % 4 == 0);
        if (good) begin
            exp_led2 = ~exp_led2;
            exp_led3 = 1'b1;
            exp_cmd  = cmd_b;
        end else begin
            exp_led3 = 1'b0;
        end
        repeat (8) drive(1'b0, 2'b00, 1'b0);
    endtask

    task automatic press_btn2(input int hold);
        @(posedge CLK50);
        #1;
        BTN2 = 1'b0;
        repeat (3) @(posedge CLK50);
        #1;
        exp_led3 = 1'b1;
        repeat (hold - 3) @(posedge CLK50);
        #1;
        BTN2 = 1'b1;
        repeat (6) @(posedge CLK50);
        #1;
    endtask

    initial begin
        #50;
        check("rst_led1", LED1, 1);
        check("rst_led2", LED2, 1);
        check("rst_led3", LED3, 1);
        check("rst_tx_en", TX_EN, 0);
        check("rst_txd", TXD, 0);
        check("rst_mdc", MDC, 0);
        #50;
        BTN1 = 1'b1;
        repeat (12) @(posedge CLK50);
        #1;
        check("led1_after_10", LED1, 0);
        check("mdc_after_10", MDC, 1);
        repeat (40) @(posedge CLK50);

        send_frame(64, 8'hA5, -1, 0);
        check("good_cmd_a5", dut.u_rx_frame.cmd, 8'hA5);
        check("good_led2", LED2, 0);
        check("good_led3", LED3, 1);

        send_frame(40, 8'h11, -1, 0);
        check("short_led3", LED3, 0);
        check("short_cmd", dut.u_rx_frame.cmd, 8'hA5);
        check("short_led2", LED2, 0);

        press_btn2(4);
        check("btn2_clear", LED3, 1);

        send_frame(63, 8'h22, -1, 0);
        check("len63_led3", LED3, 0);
        send_frame(64, 8'h33, -1, 2);
        check("misaligned_cmd", dut.u_rx_frame.cmd, 8'hA5);

        send_frame(100, 8'h5A, -1, 0);
        check("good_clears_led3", LED3, 1);
        check("good2_led2", LED2, 1);
        check("good2_cmd", dut.u_rx_frame.cmd, 8'h5A);

        send_frame(70, 8'h44, 30, 0);
        check("rx_er_led3", LED3, 0);
        check("rx_er_cmd", dut.u_rx_frame.cmd, 8'h5A);
        press_btn2(4);

        for (int i = 0; i < 10; i++) drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 2'b00, 1'b0);
        repeat (8) drive(1'b0, 2'b00, 1'b0);
        check("broken_pre_led2", LED2, 1);
        check("broken_pre_led3", LED3, 1);

        send_frame(64, 8'h66, -1, 0);
        for (int i = 0; i < 31; i++) drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 20; i++) send_byte((i == 14) ? 8'h77 : 8'(i), 1'b0);
        drive(1'b1, 2'b00, 1'b0);
        BTN1     = 1'b0;
        exp_led2 = 1'b1;
        exp_led3 = 1'b1;
        exp_cmd  = 8'h00;
        repeat (5) drive(1'b1, 2'b00, 1'b0);
        BTN1 = 1'b1;
        repeat (30) drive(1'b1, 2'b00, 1'b0);
        repeat (8) drive(1'b0, 2'b00, 1'b0);
        check("midreset_cmd", dut.u_rx_frame.cmd, 8'h00);
        check("midreset_led2", LED2, 1);

        send_frame(64, 8'hC3, -1, 0);
        check("recover_cmd", dut.u_rx_frame.cmd, 8'hC3);

`ifdef MAIN_TX_BEACON_EN
        begin
            int guard;
            int high;
            int seen;
            repeat (400) @(posedge CLK50);
            #1;
            BTN2  = 1'b0;
            guard = 0;
            while (TX_EN !== 1'b1 && guard < 20) begin
                @(posedge CLK50);
                #1;
                guard++;
            end
            check("beacon_start", TX_EN, 1);
            BTN2 = 1'b1;
            high = 0;
            for (int i = 0; i < 400 && TX_EN === 1'b1; i++) begin
                if (i < 32) check("beacon_dibit", TXD, (i == 31) ? 2'b11 : 2'b01);
                high++;
                @(posedge CLK50);
                #1;
            end
            check("beacon_len", high, 288);
            BTN2 = 1'b0;
            repeat (4) @(posedge CLK50);
            #1;
            BTN2 = 1'b1;
            seen = 0;
            for (int i = 0; i < 60; i++) begin
                if (TX_EN === 1'b1) seen++;
                @(posedge CLK50);
                #1;
            end
            check("gap_press_ignored", seen, 0);
        end
`endif

        repeat (20) @(posedge CLK50);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        errors++;
        $display("FAIL watchdog: run still active at %0t, required completion before 3 ms", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
